// File: rtl/memory_access_if.sv
// EX/MEM-to-MEM/WB bus for the memory stage. The master side is the pipeline
// around the stage; the slave side is the memory_access stage itself.
interface memory_access_if;
  logic [31:0] result_in;
  logic [31:0] registro_2_in;
  logic [4:0]  reg_dest_in;
  logic [10:0] jump_dest_addr_in;
  logic        zero_signal_in;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        Branch_in;

  logic [31:0] read_data_out;
  logic [31:0] result_out;
  logic [4:0]  reg_dest_out;
  logic        MemToReg_out;
  logic        RegWrite_out;
  logic        pc_src_out;
  logic [10:0] branch_addr_out;
  logic        mem_ready;

  modport master (
    output result_in, registro_2_in, reg_dest_in, jump_dest_addr_in,
           zero_signal_in, MemToReg_in, RegWrite_in, MemRead_in,
           MemWrite_in, Branch_in,
    input  read_data_out, result_out, reg_dest_out, MemToReg_out,
           RegWrite_out, pc_src_out, branch_addr_out, mem_ready
  );

  modport slave (
    input  result_in, registro_2_in, reg_dest_in, jump_dest_addr_in,
           zero_signal_in, MemToReg_in, RegWrite_in, MemRead_in,
           MemWrite_in, Branch_in,
    output read_data_out, result_out, reg_dest_out, MemToReg_out,
           RegWrite_out, pc_src_out, branch_addr_out, mem_ready
  );
endinterface

// File: rtl/memory_access.sv
// MEM stage: word-organised data memory with post-reset clear sequencer,
// branch resolution and the MEM/WB pipeline register.
module memory_access #(
  parameter int ADDR_W = 8
) (
  input logic            clock,
  input logic            reset,
  memory_access_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] clear_cnt_reg;
  logic              mem_ready_reg;
  logic [31:0]       read_data_reg;
  logic [31:0]       result_reg;
  logic [4:0]        reg_dest_reg;
  logic              mem_to_reg_reg;
  logic              reg_write_reg;

  logic [31:0] mem [0:DEPTH-1];

  logic              run;
  logic [ADDR_W-1:0] word_idx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign run      = (state_reg == RUN);
  // Byte offset and upper address bits are dropped: aligned, wrapping accesses.
  assign word_idx = bus.result_in[ADDR_W+1:2];

  // The single write port is shared between the clear sequencer and stores.
  assign mem_we    = !reset && (!run || bus.MemWrite_in);
  assign mem_waddr = run ? word_idx : clear_cnt_reg;
  assign mem_wdata = run ? bus.registro_2_in : 32'd0;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    // Non-blocking read alongside the write gives read-before-write data.
    if (reset || !run || !bus.MemRead_in) begin
      read_data_reg <= 32'd0;
    end else begin
      read_data_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= CLEAR;
      clear_cnt_reg  <= '0;
      mem_ready_reg  <= 1'b0;
      result_reg     <= 32'd0;
      reg_dest_reg   <= 5'd0;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clear_cnt_reg  <= clear_cnt_reg + 1'b1;
          result_reg     <= 32'd0;
          reg_dest_reg   <= 5'd0;
          mem_to_reg_reg <= 1'b0;
          reg_write_reg  <= 1'b0;
          if (clear_cnt_reg == LAST_WORD) begin
            state_reg     <= RUN;
            mem_ready_reg <= 1'b1;
          end
        end
        RUN: begin
          result_reg     <= bus.result_in;
          reg_dest_reg   <= bus.reg_dest_in;
          mem_to_reg_reg <= bus.MemToReg_in;
          reg_write_reg  <= bus.RegWrite_in;
        end
        default: begin
          state_reg     <= CLEAR;
          clear_cnt_reg <= '0;
          mem_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_data_out   = read_data_reg;
  assign bus.result_out      = result_reg;
  assign bus.reg_dest_out    = reg_dest_reg;
  assign bus.MemToReg_out    = mem_to_reg_reg;
  assign bus.RegWrite_out    = reg_write_reg;
  assign bus.mem_ready       = mem_ready_reg;
  assign bus.pc_src_out      = bus.Branch_in & bus.zero_signal_in & mem_ready_reg;
  assign bus.branch_addr_out = bus.jump_dest_addr_in;
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a 16-word memory.
module tb_memory_access;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  memory_access_if bus ();

  memory_access #(.ADDR_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.result_in         = 32'd0;
    bus.registro_2_in     = 32'd0;
    bus.reg_dest_in       = 5'd0;
    bus.MemToReg_in       = 1'b0;
    bus.RegWrite_in       = 1'b0;
    bus.MemRead_in        = 1'b0;
    bus.MemWrite_in       = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    idle();
    bus.result_in     = addr;
    bus.registro_2_in = data;
    bus.MemWrite_in   = 1'b1;
    tick();
    $display("store addr=%h data=%h", addr, data);
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                      input logic [31:0] exp);
    idle();
    bus.result_in   = addr;
    bus.reg_dest_in = rd;
    bus.MemToReg_in = 1'b1;
    bus.RegWrite_in = 1'b1;
    bus.MemRead_in  = 1'b1;
    tick();
    chk(tag, bus.read_data_out, exp);
    chk({tag, "_rd"}, {27'd0, bus.reg_dest_out}, {27'd0, rd});
    chk({tag, "_m2r"}, {31'd0, bus.MemToReg_out}, 32'd1);
    chk({tag, "_res"}, bus.result_out, addr);
    $display("load addr=%h data=%h rd=%0d", addr, bus.read_data_out, bus.reg_dest_out);
  endtask

  initial begin
    idle();
    bus.zero_signal_in    = 1'b1;
    bus.Branch_in         = 1'b1;
    bus.jump_dest_addr_in = 11'h2A5;
    bus.RegWrite_in       = 1'b1;
    bus.result_in         = 32'h1234_5678;

    // Reset held three cycles: all MEM/WB fields and mem_ready cleared.
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_rdata", bus.read_data_out, 32'd0);
    chk("rst_result", bus.result_out, 32'd0);
    chk("rst_regwr", {31'd0, bus.RegWrite_out}, 32'd0);
    chk("rst_rd", {27'd0, bus.reg_dest_out}, 32'd0);
    chk("rst_m2r", {31'd0, bus.MemToReg_out}, 32'd0);
    chk("rst_pcsrc", {31'd0, bus.pc_src_out}, 32'd0);
    $display("reset done");

    // Partial clear, then reset at clear count 7.
    reset = 1'b0;
    repeat (7) tick();
    chk("mid_ready", {31'd0, bus.mem_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset mid-clear");

    // Restarted clear: 15 edges still not ready; RegWrite and branch suppressed.
    for (int i = 0; i < 15; i++) begin
      if (i == 12) begin
        bus.result_in     = 32'd0;
        bus.registro_2_in = 32'hFFFF_FFFF;
        bus.MemWrite_in   = 1'b1;
        bus.MemRead_in    = 1'b1;
        bus.RegWrite_in   = 1'b1;
      end
      tick();
      chk("clr_ready", {31'd0, bus.mem_ready}, 32'd0);
      chk("clr_regwr", {31'd0, bus.RegWrite_out}, 32'd0);
      chk("clr_pcsrc", {31'd0, bus.pc_src_out}, 32'd0);
      chk("clr_rdata", bus.read_data_out, 32'd0);
      $display("clear cycle %0d ready=%b", i + 1, bus.mem_ready);
    end
    idle();
    tick();
    chk("clr_done", {31'd0, bus.mem_ready}, 32'd1);
    $display("clear done ready=%b", bus.mem_ready);

    // Branch resolution is combinational once ready.
    #1;
    chk("br_take", {31'd0, bus.pc_src_out}, 32'd1);
    chk("br_addr", {21'd0, bus.branch_addr_out}, 32'h0000_02A5);
    bus.zero_signal_in = 1'b0;
    #1;
    chk("br_nz", {31'd0, bus.pc_src_out}, 32'd0);
    bus.Branch_in = 1'b0;
    $display("branch checks done");

    // Every word reads back zero after clear (word 0 included despite the CLEAR store).
    for (int w = 0; w < 16; w++) begin
      load("clr_word", 32'(w * 4), 5'(w), 32'd0);
    end

    // Store then immediate load of the same word with unaligned byte offset.
    store(32'h0000_0014, 32'hDEAD_BEEF);
    load("st_ld", 32'h0000_0017, 5'd9, 32'hDEAD_BEEF);

    // Address wrap: 0x40 aliases word 0 in a 16-word memory.
    store(32'h0000_0040, 32'h1234_5678);
    load("wrap", 32'h0000_0000, 5'd3, 32'h1234_5678);

    // Simultaneous read/write returns old contents.
    store(32'h0000_000C, 32'hAAAA_0000);
    idle();
    bus.result_in     = 32'h0000_000C;
    bus.registro_2_in = 32'h5555_FFFF;
    bus.MemRead_in    = 1'b1;
    bus.MemWrite_in   = 1'b1;
    tick();
    chk("rbw_old", bus.read_data_out, 32'hAAAA_0000);
    $display("rw addr=0c data=%h", bus.read_data_out);
    load("rbw_new", 32'h0000_000C, 5'd12, 32'h5555_FFFF);

    // No load: read data bubbles to zero; RegWrite passes through.
    idle();
    bus.result_in   = 32'hCAFE_0001;
    bus.RegWrite_in = 1'b1;
    bus.reg_dest_in = 5'd31;
    tick();
    chk("noread", bus.read_data_out, 32'd0);
    chk("alu_res", bus.result_out, 32'hCAFE_0001);
    chk("alu_regwr", {31'd0, bus.RegWrite_out}, 32'd1);
    chk("alu_rd", {27'd0, bus.reg_dest_out}, 32'd31);
    $display("alu op result=%h rd=%0d", bus.result_out, bus.reg_dest_out);

    // Reset from RUN drops readiness and gates branches.
    bus.Branch_in      = 1'b1;
    bus.zero_signal_in = 1'b1;
    reset = 1'b1;
    tick();
    chk("rerst_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rerst_pcsrc", {31'd0, bus.pc_src_out}, 32'd0);
    chk("rerst_regwr", {31'd0, bus.RegWrite_out}, 32'd0);
    $display("re-reset ready=%b", bus.mem_ready);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
